// File: rtl/counter_pkg.sv
// counter_pkg: shared definitions for the general-purpose up_counter.
//   COUNTER_DEFAULT_WIDTH : default counter width in bits.
//   ovf_mode_e            : meaning of the STICKY_OVERFLOW parameter
//                           (0 = one-cycle pulse per wrap, 1 = hold until clear/reset).
package counter_pkg;

  localparam int unsigned COUNTER_DEFAULT_WIDTH = 8;

  typedef enum logic {
    OVF_PULSE  = 1'b0,
    OVF_STICKY = 1'b1
  } ovf_mode_e;

endpackage : counter_pkg

// File: rtl/up_counter.sv
// up_counter: parameterised synchronous up-counter with enable, synchronous
// clear and a registered carry-out/overflow flag. Typical use is a watchdog
// timer: free-running clock, enabled by the environment, periodically cleared,
// overflow raised on expiry.
//
// Parameters:
//   WIDTH           : counter width, 1..32.
//   INCREMENT_RATE  : step per enabled cycle, 1..2**WIDTH-1.
//   STICKY_OVERFLOW : 0 = overflow pulses for one cycle per wrap,
//                     1 = overflow holds until clear or reset.
// Ports:
//   clk       : clock, all state updates on the rising edge.
//   rst       : asynchronous active-high reset (count_val=0, overflow=0).
//   en        : count enable.
//   clear     : synchronous clear of count and overflow; beats en.
//   overflow  : registered carry-out flag.
//   count_val : registered current count.
module up_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH           = COUNTER_DEFAULT_WIDTH,
  parameter int unsigned INCREMENT_RATE  = 1,
  parameter int unsigned STICKY_OVERFLOW = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  output logic             overflow,
  output logic [WIDTH-1:0] count_val
);

  // Elaboration-time legality checks.
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $fatal(1, "up_counter: WIDTH=%0d outside 1..32", WIDTH);
  end

  if (INCREMENT_RATE < 1 ||
      longint'(INCREMENT_RATE) > ((longint'(1) << WIDTH) - longint'(1))) begin : g_bad_rate
    $fatal(1, "up_counter: INCREMENT_RATE=%0d outside 1..2**WIDTH-1", INCREMENT_RATE);
  end

  if (STICKY_OVERFLOW > 1) begin : g_bad_mode
    $fatal(1, "up_counter: STICKY_OVERFLOW=%0d must be 0 or 1", STICKY_OVERFLOW);
  end

  localparam ovf_mode_e      MODE = (STICKY_OVERFLOW == 1) ? OVF_STICKY : OVF_PULSE;
  localparam logic [WIDTH:0] INC  = (WIDTH+1)'(INCREMENT_RATE);

  // One extra bit captures the carry out of the wrap.
  logic [WIDTH:0] sum;

  always_comb begin
    sum = {1'b0, count_val} + INC;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_val <= '0;
      overflow  <= 1'b0;
    end else if (clear) begin
      count_val <= '0;
      overflow  <= 1'b0;
    end else if (en) begin
      count_val <= sum[WIDTH-1:0];
      if (MODE == OVF_STICKY) begin
        overflow <= overflow | sum[WIDTH];
      end else begin
        overflow <= sum[WIDTH];
      end
    end else if (MODE == OVF_PULSE) begin
      // Idle cycle ends any pulse; sticky mode keeps its flag.
      overflow <= 1'b0;
    end
  end

endmodule : up_counter

// File: tb/tb_up_counter.sv
// Directed self-checking bench for up_counter: three instances cover
// WIDTH=6 rate 1 pulse mode, WIDTH=4 rate 3, and WIDTH=3 sticky mode.
module tb_up_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // WIDTH=6, rate 1, pulse
  logic       rst6, en6, clr6, ovf6;
  logic [5:0] cnt6;
  // WIDTH=4, rate 3, pulse
  logic       rst4, en4, clr4, ovf4;
  logic [3:0] cnt4;
  // WIDTH=3, rate 1, sticky
  logic       rst3, en3, clr3, ovf3;
  logic [2:0] cnt3;

  up_counter #(.WIDTH(6), .INCREMENT_RATE(1), .STICKY_OVERFLOW(0)) u_c6 (
    .clk(clk), .rst(rst6), .en(en6), .clear(clr6), .overflow(ovf6), .count_val(cnt6));
  up_counter #(.WIDTH(4), .INCREMENT_RATE(3), .STICKY_OVERFLOW(0)) u_c4 (
    .clk(clk), .rst(rst4), .en(en4), .clear(clr4), .overflow(ovf4), .count_val(cnt4));
  up_counter #(.WIDTH(3), .INCREMENT_RATE(1), .STICKY_OVERFLOW(1)) u_c3 (
    .clk(clk), .rst(rst3), .en(en3), .clear(clr3), .overflow(ovf3), .count_val(cnt3));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge and sample 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int unsigned seq4 [7] = '{3, 6, 9, 12, 15, 2, 5};
  int unsigned ovf4e[7] = '{0, 0, 0, 0, 0, 1, 0};

  initial begin
    rst6 = 1'b1; en6 = 1'b0; clr6 = 1'b0;
    rst4 = 1'b1; en4 = 1'b0; clr4 = 1'b0;
    rst3 = 1'b1; en3 = 1'b0; clr3 = 1'b0;
    #1;
    check_val("rst6_cnt", 32'(cnt6), 0);
    check_val("rst6_ovf", 32'(ovf6), 0);
    check_val("rst4_cnt", 32'(cnt4), 0);
    check_val("rst3_ovf", 32'(ovf3), 0);

    @(negedge clk);
    rst6 = 1'b0; rst4 = 1'b0; rst3 = 1'b0;

    // --- WIDTH=6: 63 edges, wrap on the 64th, 1 on the 65th
    en6 = 1'b1;
    for (int i = 0; i < 63; i++) tick();
    check_val("w6_63_cnt", 32'(cnt6), 63);
    check_val("w6_63_ovf", 32'(ovf6), 0);
    tick();
    check_val("w6_64_cnt", 32'(cnt6), 0);
    check_val("w6_64_ovf", 32'(ovf6), 1);
    tick();
    check_val("w6_65_cnt", 32'(cnt6), 1);
    check_val("w6_65_ovf", 32'(ovf6), 0);
    en6 = 1'b0;
    tick();
    check_val("w6_hold_cnt", 32'(cnt6), 1);

    // --- count to 5, hold 4 cycles, then clear+en together
    clr6 = 1'b1; tick(); clr6 = 1'b0;
    check_val("clr_cnt", 32'(cnt6), 0);
    en6 = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check_val("to5_cnt", 32'(cnt6), 5);
    en6 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val("hold5_cnt", 32'(cnt6), 5);
    end
    en6 = 1'b1; clr6 = 1'b1;
    tick();
    check_val("clr_en_cnt", 32'(cnt6), 0);
    check_val("clr_en_ovf", 32'(ovf6), 0);
    clr6 = 1'b0;

    // --- async reset mid-count at 40
    for (int i = 0; i < 40; i++) tick();
    check_val("to40_cnt", 32'(cnt6), 40);
    #2;
    rst6 = 1'b1;
    #1;
    check_val("async_rst_cnt", 32'(cnt6), 0);
    check_val("async_rst_ovf", 32'(ovf6), 0);
    tick();
    check_val("rst_hold_cnt", 32'(cnt6), 0);
    rst6 = 1'b0;
    tick();
    check_val("resume_cnt", 32'(cnt6), 1);

    // --- clear on the wrapping edge suppresses the pulse
    clr6 = 1'b1; tick(); clr6 = 1'b0;
    for (int i = 0; i < 62; i++) tick();
    check_val("to62_cnt", 32'(cnt6), 62);
    tick();
    check_val("to63_cnt", 32'(cnt6), 63);
    clr6 = 1'b1;
    tick();
    check_val("clr_wrap_cnt", 32'(cnt6), 0);
    check_val("clr_wrap_ovf", 32'(ovf6), 0);
    clr6 = 1'b0; en6 = 1'b0;
    tick();
    check_val("no_late_pulse", 32'(ovf6), 0);

    // --- WIDTH=4, rate 3: 3,6,9,12,15,2(ovf),5
    en4 = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      check_val("w4_cnt", 32'(cnt4), seq4[i]);
      check_val("w4_ovf", 32'(ovf4), ovf4e[i]);
    end
    en4 = 1'b0;

    // --- WIDTH=3 sticky
    en3 = 1'b1;
    for (int i = 1; i <= 7; i++) tick();
    check_val("st_7_cnt", 32'(cnt3), 7);
    check_val("st_7_ovf", 32'(ovf3), 0);
    tick();
    check_val("st_wrap_cnt", 32'(cnt3), 0);
    check_val("st_wrap_ovf", 32'(ovf3), 1);
    tick();
    check_val("st_en_cnt", 32'(cnt3), 1);
    check_val("st_en_ovf", 32'(ovf3), 1);
    en3 = 1'b0;
    tick(); tick();
    check_val("st_idle_cnt", 32'(cnt3), 1);
    check_val("st_idle_ovf", 32'(ovf3), 1);
    clr3 = 1'b1;
    tick();
    check_val("st_clr_cnt", 32'(cnt3), 0);
    check_val("st_clr_ovf", 32'(ovf3), 0);
    clr3 = 1'b0;
    tick();
    check_val("st_after_ovf", 32'(ovf3), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_up_counter
